// File: rtl/matrix_commutator.sv
// matrix_commutator: four-step current-sign commutation controller for one matrix-converter output leg
//   clk           rising-edge system clock
//   rst_n         asynchronous active-low reset
//   en_i          run enable, low forces IDLE unless faulted
//   short_i       short-circuit detect, level sampled on clk
//   fault_clr_i   clears a latched fault once short_i is low
//   req_sel_i     requested input phase, 0 = none
//   cur_sign_i    output current sign, 1 = conducted by fwd devices
//   gate_o        gate drives, bit 2k = fwd of phase k+1, bit 2k+1 = rev of phase k+1
//   active_sel_o  phase currently fully connected, 0 when none
//   busy_o        commutation sequence in progress
//   fault_o       latched short fault
module matrix_commutator #(
    parameter int N_IN     = 3,
    parameter int SEL_W    = 2,
    parameter int STEP_CYC = 4,
    parameter int CNT_W    = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en_i,
    input  logic                short_i,
    input  logic                fault_clr_i,
    input  logic [SEL_W-1:0]    req_sel_i,
    input  logic                cur_sign_i,
    output logic [2*N_IN-1:0]   gate_o,
    output logic [SEL_W-1:0]    active_sel_o,
    output logic                busy_o,
    output logic                fault_o
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ON    = 3'd1;
    localparam logic [2:0] S1    = 3'd2;
    localparam logic [2:0] S2    = 3'd3;
    localparam logic [2:0] S3    = 3'd4;
    localparam logic [2:0] FAULT = 3'd5;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STEP_CYC - 1);

    logic [2:0]        state_q, state_d;
    logic [SEL_W-1:0]  cur_q, cur_d, tgt_q, tgt_d;
    logic              sgn_q, sgn_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*N_IN-1:0] gate_q, gate_d;
    logic              busy_q, busy_d, fault_q, fault_d;
    logic              req_ok;

    // Conducting device of phase p for current sign s (fwd when s=1).
    function automatic logic [2*N_IN-1:0] cond(input logic [SEL_W-1:0] p, input logic s);
        cond = '0;
        for (int k = 0; k < N_IN; k++)
            if (p == SEL_W'(k + 1)) begin
                cond[2*k]   = s;
                cond[2*k+1] = !s;
            end
    endfunction

    assign req_ok = (req_sel_i != '0) && (req_sel_i <= SEL_W'(N_IN));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        sgn_d   = sgn_q;
        cnt_d   = cnt_q;
        if (short_i) begin
            state_d = FAULT;
            cur_d   = '0;
            cnt_d   = '0;
        end else if (state_q == FAULT) begin
            if (fault_clr_i) state_d = IDLE;
        end else if (!en_i) begin
            state_d = IDLE;
            cur_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: if (req_ok) begin
                    state_d = ON;
                    cur_d   = req_sel_i;
                end
                ON: if (req_sel_i == '0) begin
                    state_d = IDLE;
                    cur_d   = '0;
                end else if (req_ok && req_sel_i != cur_q) begin
                    state_d = S1;
                    tgt_d   = req_sel_i;
                    sgn_d   = cur_sign_i;
                    cnt_d   = RELOAD;
                end
                // Intermediate steps ignore requests; only the dwell counter moves them on.
                S1, S2, S3: if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = (state_q == S3) ? ON : state_q + 3'd1;
                    cnt_d   = (state_q == S3) ? '0 : RELOAD;
                    cur_d   = (state_q == S3) ? tgt_q : cur_q;
                end
                default: state_d = IDLE;
            endcase
        end
        // Outputs are decoded from next state so every output is a plain register.
        gate_d  = (state_d == ON) ? (cond(cur_d, 1'b1) | cond(cur_d, 1'b0)) :
                  (state_d == S1) ? cond(cur_d, sgn_d) :
                  (state_d == S2) ? (cond(cur_d, sgn_d) | cond(tgt_d, sgn_d)) :
                  (state_d == S3) ? cond(tgt_d, sgn_d) : '0;
        busy_d  = (state_d == S1) || (state_d == S2) || (state_d == S3);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= '0;
            tgt_q   <= '0;
            sgn_q   <= 1'b0;
            cnt_q   <= '0;
            gate_q  <= '0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            sgn_q   <= sgn_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            fault_q <= fault_d;
        end
    end

    assign gate_o       = gate_q;
    assign active_sel_o = cur_q;
    assign busy_o       = busy_q;
    assign fault_o      = fault_q;
endmodule

// File: tb/tb_matrix_commutator.sv
// tb_matrix_commutator: directed table for a 3-phase leg plus randomized model check of a 5-phase leg
module tb_matrix_commutator;
    localparam int N5 = 5;
    localparam int S5 = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       en3 = 0, sh3 = 0, clr3 = 0, sgn3 = 0;
    logic [1:0] req3 = 0;
    logic [5:0] g3;
    logic [1:0] a3;
    logic       b3, f3;

    logic       en5 = 0, sh5 = 0, clr5 = 0, sgn5 = 0;
    logic [2:0] req5 = 0;
    logic [9:0] g5;
    logic [2:0] a5;
    logic       b5, f5;

    matrix_commutator #(.N_IN(3), .SEL_W(2), .STEP_CYC(4), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en_i(en3), .short_i(sh3), .fault_clr_i(clr3),
        .req_sel_i(req3), .cur_sign_i(sgn3), .gate_o(g3), .active_sel_o(a3),
        .busy_o(b3), .fault_o(f3));

    matrix_commutator #(.N_IN(N5), .SEL_W(3), .STEP_CYC(S5), .CNT_W(1)) dut5 (
        .clk(clk), .rst_n(rst_n), .en_i(en5), .short_i(sh5), .fault_clr_i(clr5),
        .req_sel_i(req5), .cur_sign_i(sgn5), .gate_o(g5), .active_sel_o(a5),
        .busy_o(b5), .fault_o(f5));

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Safety rule: at most two gates, and two phases only ever share one polarity.
    function automatic logic safe(input logic [9:0] g);
        int n = 0;
        int p[2] = '{0, 0};
        for (int i = 0; i < 10; i++)
            if (g[i]) begin
                if (n < 2) p[n] = i;
                n++;
            end
        if (n > 2) return 1'b0;
        if (n == 2 && (p[0] / 2 != p[1] / 2) && (p[0] % 2 != p[1] % 2)) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk)
        if (rst_n) begin
            chk("safe3", 32'(safe({4'b0, g3})), 32'd1);
            chk("safe5", 32'(safe(g5)), 32'd1);
        end

    typedef struct {
        logic en, sh, clr;
        logic [1:0] req;
        logic sgn;
        int n;
        logic [5:0] gate;
        logic [1:0] act;
        logic busy, flt;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic en, sh, clr, input logic [1:0] req, input logic sgn, input int n,
                       input logic [5:0] gate, input logic [1:0] act, input logic busy, flt);
        vec_t v;
        v = '{en, sh, clr, req, sgn, n, gate, act, busy, flt};
        tbl.push_back(v);
    endtask

    // Reference model: a commutation is a precomputed list of per-cycle outputs.
    typedef struct {logic [9:0] g; logic [2:0] a; logic b;} ent_t;
    ent_t q[$];
    logic [9:0] e_gate;
    logic [2:0] e_act;
    logic       e_busy, e_fault;

    function automatic logic [9:0] cd(input int p, input logic s);
        return 10'd1 << (2 * (p - 1) + (s ? 0 : 1));
    endfunction

    function automatic logic [9:0] both(input int p);
        return 10'b11 << (2 * (p - 1));
    endfunction

    task automatic model_step(input logic en, sh, clr, input logic [2:0] req, input logic s);
        ent_t e;
        bit ok;
        ok = req != 0 && req <= N5;
        if (sh) begin
            {e_gate, e_act, e_busy, e_fault} = {10'b0, 3'b0, 1'b0, 1'b1};
            q.delete();
        end else if (e_fault) begin
            if (clr) e_fault = 1'b0;
        end else if (!en) begin
            {e_gate, e_act, e_busy} = '0;
            q.delete();
        end else if (q.size() > 0) begin
            e = q.pop_front();
            {e_gate, e_act, e_busy} = {e.g, e.a, e.b};
        end else if (e_act == 0) begin
            if (ok) begin
                e_act = req;
                e_gate = both(req);
            end
        end else if (req == 0) begin
            {e_gate, e_act, e_busy} = '0;
        end else if (ok && req != e_act) begin
            for (int k = 0; k < S5; k++) q.push_back('{cd(e_act, s), e_act, 1'b1});
            for (int k = 0; k < S5; k++) q.push_back('{cd(e_act, s) | cd(req, s), e_act, 1'b1});
            for (int k = 0; k < S5; k++) q.push_back('{cd(req, s), e_act, 1'b1});
            q.push_back('{both(req), req, 1'b0});
            e = q.pop_front();
            {e_gate, e_act, e_busy} = {e.g, e.a, e.b};
        end
    endtask

    initial begin
        add(1,0,0,1,1,1,6'b000011,1,0,0);
        add(1,0,0,2,1,4,6'b000001,1,1,0);
        add(1,0,0,2,1,4,6'b000101,1,1,0);
        add(1,0,0,2,1,4,6'b000100,1,1,0);
        add(1,0,0,2,1,1,6'b001100,2,0,0);
        add(1,0,0,3,0,4,6'b001000,2,1,0);
        add(1,0,0,3,0,4,6'b101000,2,1,0);
        add(1,0,0,3,0,4,6'b100000,2,1,0);
        add(1,0,0,3,0,2,6'b110000,3,0,0);
        add(1,0,0,0,0,1,6'b000000,0,0,0);
        add(1,0,0,1,1,1,6'b000011,1,0,0);
        add(1,0,0,3,1,1,6'b000001,1,1,0);
        add(1,0,0,2,0,3,6'b000001,1,1,0);
        add(1,0,0,2,0,4,6'b010001,1,1,0);
        add(1,0,0,2,0,4,6'b010000,1,1,0);
        add(1,0,0,2,0,1,6'b110000,3,0,0);
        add(1,0,0,1,1,4,6'b010000,3,1,0);
        add(1,0,0,1,1,1,6'b010001,3,1,0);
        add(1,1,0,1,1,1,6'b000000,0,0,1);
        add(1,1,1,1,1,2,6'b000000,0,0,1);
        add(1,0,1,1,1,1,6'b000000,0,0,0);
        add(1,0,0,1,1,1,6'b000011,1,0,0);
        add(1,0,0,2,1,4,6'b000001,1,1,0);
        add(1,0,0,2,1,4,6'b000101,1,1,0);
        add(1,0,0,2,1,1,6'b000100,1,1,0);
        add(0,0,0,2,1,2,6'b000000,0,0,0);
        add(1,0,0,2,1,1,6'b001100,2,0,0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst gate", 32'(g3), 0);
        chk("rst act", 32'(a3), 0);
        chk("rst busy", 32'(b3), 0);
        chk("rst fault", 32'(f3), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            {en3, sh3, clr3, req3, sgn3} = {tbl[i].en, tbl[i].sh, tbl[i].clr, tbl[i].req, tbl[i].sgn};
            repeat (tbl[i].n) begin
                @(posedge clk);
                #1;
                chk($sformatf("row%0d gate", i), 32'(g3), 32'(tbl[i].gate));
                chk($sformatf("row%0d act", i), 32'(a3), 32'(tbl[i].act));
                chk($sformatf("row%0d busy", i), 32'(b3), 32'(tbl[i].busy));
                chk($sformatf("row%0d fault", i), 32'(f3), 32'(tbl[i].flt));
            end
        end

        // Async reset in the middle of S2 clears at once and completes no step.
        {req3, sgn3} = {2'd3, 1'b1};
        repeat (6) @(posedge clk);
        #1;
        chk("mid S2 gate", 32'(g3), 32'(6'b011100 & 6'b010100));
        #2 rst_n = 1'b0;
        #1;
        chk("async gate", 32'(g3), 0);
        chk("async act", 32'(a3), 0);
        chk("async busy", 32'(b3), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post rst gate", 32'(g3), 32'(6'b110000));
        chk("post rst act", 32'(a3), 3);
        en3 = 1'b0;

        {e_gate, e_act, e_busy, e_fault} = '0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            en5 = ($urandom % 32) != 0;
            sh5 = ($urandom % 64) == 0;
            clr5 = ($urandom % 4) == 0;
            sgn5 = 1'($urandom);
            if ($urandom % 3 == 0) req5 = 3'($urandom % 8);
            @(posedge clk);
            model_step(en5, sh5, clr5, req5, sgn5);
            #1;
            chk($sformatf("rnd%0d", c), {18'b0, g5, a5, b5, f5}, {18'b0, e_gate, e_act, e_busy, e_fault});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
